// File: rtl/mem_bus_mux.sv
// mem_bus_mux: CPU-side memory interconnect.
// Decodes the CPU address against NUM_SLAVES prefixes (lowest index wins on
// overlap), drives a one-hot chip select, muxes the selected slave's
// read data/ready into a registered one-cycle response, and flags unmapped
// accesses and slave timeouts on a sticky bus_err.
// Optional build macro: MEM_BUS_MUX_ERR_CAPTURE_EN adds err_addr/err_count.
//
// Handshake: a request is cpu_valid && !cpu_ready seen in IDLE. The CPU holds
// cpu_valid and the address stable until cpu_ready pulses for one cycle; the
// response (cpu_rdata) is valid only in that cycle. Slaves see slv_cs for the
// whole access and answer with slv_ready for at least one cycle.
module mem_bus_mux #(
  parameter int NUM_SLAVES     = 8,
  parameter int PREFIX_MSB     = 31,
  parameter int PREFIX_LSB     = 24,
  parameter logic [NUM_SLAVES*(PREFIX_MSB-PREFIX_LSB+1)-1:0] SLAVE_PREFIXES = '0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_valid,
  input  logic [31:0]              cpu_addr,
  input  logic [3:0]               cpu_wstrb,
  input  logic [31:0]              cpu_wdata,
  output logic                     cpu_ready,
  output logic [31:0]              cpu_rdata,
  input  logic                     force_jump,
  input  logic [31:0]              jump_instr,
  output logic [NUM_SLAVES-1:0]    slv_cs,
  output logic                     slv_we,
  output logic [3:0]               slv_wstrb,
  output logic [31:0]              slv_addr,
  output logic [31:0]              slv_wdata,
  input  logic [NUM_SLAVES*32-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]    slv_ready,
  output logic                     bus_err,
  input  logic                     err_clear,
`ifdef MEM_BUS_MUX_ERR_CAPTURE_EN
  output logic [31:0]              err_addr,
  output logic [7:0]               err_count,
`endif
  output logic [1:0]               dbg_state
);

  localparam int W     = PREFIX_MSB - PREFIX_LSB + 1;
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state, nxt_state;
  logic [IDX_W-1:0] cur_idx;
  logic [CNT_W-1:0] cnt;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [31:0]      sel_rdata;
  logic             sel_ready;
  logic             req;
  logic             tmo_hit;
  logic             resp_fire;
  logic [31:0]      resp_data;
  logic             err_set;
  logic             enter_wait;

  assign dbg_state = state;

  // Write-side signals go straight through to every slave.
  assign slv_we    = |cpu_wstrb;
  assign slv_wstrb = cpu_wstrb;
  assign slv_addr  = cpu_addr;
  assign slv_wdata = cpu_wdata;

  assign req     = cpu_valid && !cpu_ready;
  assign sel_idx = (state == ST_WAIT) ? cur_idx : hit_idx;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Prefix decode; scanning downward lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (cpu_addr[PREFIX_MSB:PREFIX_LSB] == SLAVE_PREFIXES[i*W +: W]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Read-data / ready mux for the currently addressed slave.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_rdata = slv_rdata[i*32 +: 32];
        sel_ready = slv_ready[i];
      end
    end
  end

  // Chip select: decoded in IDLE, held from the latched index in WAIT, and
  // forced low while reset is asserted.
  always_comb begin
    slv_cs = '0;
    if (!reset) begin
      if (state == ST_IDLE && req && !force_jump && hit)
        slv_cs = NUM_SLAVES'(1) << hit_idx;
      else if (state == ST_WAIT)
        slv_cs = NUM_SLAVES'(1) << cur_idx;
    end
  end

  // Access FSM next-state and response selection.
  always_comb begin
    nxt_state  = state;
    resp_fire  = 1'b0;
    resp_data  = '0;
    err_set    = 1'b0;
    enter_wait = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (force_jump) begin
            nxt_state = ST_RESP;
            resp_fire = 1'b1;
            resp_data = jump_instr;
          end else if (!hit) begin
            nxt_state = ST_RESP;
            resp_fire = 1'b1;
            err_set   = 1'b1;
          end else if (sel_ready) begin
            nxt_state = ST_RESP;
            resp_fire = 1'b1;
            resp_data = sel_rdata;
          end else begin
            nxt_state  = ST_WAIT;
            enter_wait = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // An abandoned access is dropped silently; ready beats timeout.
        if (!cpu_valid) begin
          nxt_state = ST_IDLE;
        end else if (sel_ready) begin
          nxt_state = ST_RESP;
          resp_fire = 1'b1;
          resp_data = sel_rdata;
        end else if (tmo_hit) begin
          nxt_state = ST_RESP;
          resp_fire = 1'b1;
          err_set   = 1'b1;
        end
      end
      ST_RESP: nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase
  end

  // State, latched slave index and saturating wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cur_idx <= '0;
      cnt     <= '0;
    end else begin
      state <= nxt_state;
      if (enter_wait) cur_idx <= hit_idx;
      if (state == ST_WAIT) begin
        if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  // Registered CPU response; rdata holds between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ready <= resp_fire;
      if (resp_fire) cpu_rdata <= resp_data;
    end
  end

  // Sticky bus error; a new error wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          bus_err <= 1'b0;
    else if (err_set)   bus_err <= 1'b1;
    else if (err_clear) bus_err <= 1'b0;
  end

`ifdef MEM_BUS_MUX_ERR_CAPTURE_EN
  // First-error address capture and saturating error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_addr  <= '0;
      err_count <= '0;
    end else if (err_set) begin
      if (err_clear || err_count == 8'd0) begin
        err_addr  <= cpu_addr;
        err_count <= 8'd1;
      end else if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end else if (err_clear) begin
      err_addr  <= '0;
      err_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_mux.sv
// Testbench for mem_bus_mux: directed steps followed by randomized accesses,
// each checked against a transaction-level model of latency, data and errors.
module tb_mem_bus_mux;

  localparam int NS   = 8;
  localparam int PMSB = 29;
  localparam int PLSB = 24;
  localparam int TMO  = 4;
  localparam logic [NS*6-1:0] PFX =
    {6'h07, 6'h06, 6'h10, 6'h04, 6'h10, 6'h02, 6'h11, 6'h01};

  // Slave prefix table as seen by the model (slaves 3 and 5 overlap).
  logic [5:0] pfx_tab [NS] = '{6'h01, 6'h11, 6'h02, 6'h10, 6'h04, 6'h10, 6'h06, 6'h07};

  logic            clk;
  logic            reset;
  logic            cpu_valid;
  logic [31:0]     cpu_addr;
  logic [3:0]      cpu_wstrb;
  logic [31:0]     cpu_wdata;
  logic            cpu_ready;
  logic [31:0]     cpu_rdata;
  logic            force_jump;
  logic [31:0]     jump_instr;
  logic [NS-1:0]   slv_cs;
  logic            slv_we;
  logic [3:0]      slv_wstrb;
  logic [31:0]     slv_addr;
  logic [31:0]     slv_wdata;
  logic [NS*32-1:0] slv_rdata;
  logic [NS-1:0]   slv_ready;
  logic            bus_err;
  logic            err_clear;
  logic [1:0]      dbg_state;
`ifdef MEM_BUS_MUX_ERR_CAPTURE_EN
  logic [31:0]     err_addr;
  logic [7:0]      err_count;
`endif

  int vectors;
  int miscompares;

  // Model state
  bit          m_err;
  logic [31:0] m_err_addr;
  int          m_err_count;

  mem_bus_mux #(
    .NUM_SLAVES(NS), .PREFIX_MSB(PMSB), .PREFIX_LSB(PLSB),
    .SLAVE_PREFIXES(PFX), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wstrb(cpu_wstrb),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .force_jump(force_jump), .jump_instr(jump_instr),
    .slv_cs(slv_cs), .slv_we(slv_we), .slv_wstrb(slv_wstrb),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_rdata(slv_rdata),
    .slv_ready(slv_ready), .bus_err(bus_err), .err_clear(err_clear),
`ifdef MEM_BUS_MUX_ERR_CAPTURE_EN
    .err_addr(err_addr), .err_count(err_count),
`endif
    .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if (pfx_tab[i] == a[29:24]) return i;
    return -1;
  endfunction

  task automatic model_error(input logic [31:0] a);
    m_err = 1'b1;
    if (m_err_count == 0) m_err_addr = a;
    if (m_err_count < 255) m_err_count++;
  endtask

  task automatic model_reset();
    m_err       = 1'b0;
    m_err_addr  = '0;
    m_err_count = 0;
  endtask

  task automatic check_capture(input string tag);
`ifdef MEM_BUS_MUX_ERR_CAPTURE_EN
    check({tag, "_err_addr"}, err_addr, m_err_addr);
    check({tag, "_err_count"}, 32'(err_count), 32'(m_err_count));
`endif
  endtask

  // Called at a negedge: pulse err_clear for one cycle.
  task automatic pulse_clear();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    model_reset();
    check("err_clear", 32'(bus_err), 32'(m_err));
    check_capture("err_clear");
  endtask

  // Called at a negedge with the DUT idle. delay = cycles the addressed slave
  // stays not-ready after its select first appears; -1 = never ready.
  task automatic access(input string tag, input logic [31:0] addr, input logic [3:0] wstrb,
                        input bit fj, input logic [31:0] jinstr, input int delay,
                        input logic [31:0] data);
    int          k;
    int          rc;
    logic [31:0] exp_data;
    bit          exp_err;
    logic [NS-1:0] exp_cs;
    k = ref_decode(addr);
    if (fj) begin
      rc = 1; exp_data = jinstr; exp_err = 0; exp_cs = '0;
    end else if (k < 0) begin
      rc = 1; exp_data = '0; exp_err = 1; exp_cs = '0;
    end else if (delay >= 0 && delay <= TMO) begin
      rc = delay + 1; exp_data = data; exp_err = 0; exp_cs = NS'(1) << k;
    end else begin
      rc = TMO + 1; exp_data = '0; exp_err = 1; exp_cs = NS'(1) << k;
    end
    cpu_valid  = 1'b1;
    cpu_addr   = addr;
    cpu_wstrb  = wstrb;
    cpu_wdata  = $urandom;
    force_jump = fj;
    jump_instr = jinstr;
    for (int c = 0; c <= rc; c++) begin
      if (c > 0) @(negedge clk);
      if (c < rc) begin
        slv_ready = NS'($urandom);
        for (int i = 0; i < NS; i++) slv_rdata[i*32 +: 32] = $urandom;
        if (k >= 0) begin
          slv_ready[k] = (delay >= 0 && c >= delay);
          slv_rdata[k*32 +: 32] = data;
        end
        #1;
        check({tag, "_cs"}, 32'(slv_cs), 32'(exp_cs));
        if (c == 0) begin
          check({tag, "_we"}, 32'(slv_we), 32'(|wstrb));
          check({tag, "_addr"}, slv_addr, addr);
          check({tag, "_wdata"}, slv_wdata, cpu_wdata);
        end else begin
          check({tag, "_early_ready"}, 32'(cpu_ready), 32'd0);
        end
      end else begin
        if (exp_err) model_error(addr);
        check({tag, "_ready"}, 32'(cpu_ready), 32'd1);
        check({tag, "_rdata"}, cpu_rdata, exp_data);
        check({tag, "_resp_cs"}, 32'(slv_cs), 32'd0);
        check({tag, "_bus_err"}, 32'(bus_err), 32'(m_err));
        check_capture(tag);
        cpu_valid  = 1'b0;
        force_jump = 1'b0;
        slv_ready  = '0;
      end
    end
    @(negedge clk);
    check({tag, "_ready_once"}, 32'(cpu_ready), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    reset      = 1'b1;
    cpu_valid  = 1'b1;              // request during reset must not select
    cpu_addr   = 32'hC2000010;
    cpu_wstrb  = '0;
    cpu_wdata  = '0;
    force_jump = 1'b0;
    jump_instr = '0;
    slv_rdata  = '0;
    slv_ready  = '1;
    err_clear  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cs", 32'(slv_cs), 32'd0);
    check("rst_ready", 32'(cpu_ready), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check_capture("rst");
    cpu_valid = 1'b0;
    slv_ready = '0;
    reset     = 1'b0;
    @(negedge clk);

    // Immediate-ready read from slave 2
    access("rd_s2", 32'hC2000010, 4'h0, 0, '0, 0, 32'hDEADBEEF);
    // Slave 1 never ready: timeout, then clear
    access("tmo_s1", 32'h51000000, 4'h0, 0, '0, -1, 32'h11111111);
    pulse_clear();
    // Unmapped prefix 0x2A
    access("unmapped", 32'hEA000000, 4'h0, 0, '0, 0, 32'h0);
    pulse_clear();
    // Overlapping prefix: slave 3 wins over slave 5
    access("overlap", 32'h10000008, 4'h0, 0, '0, 2, 32'h12345678);
    // Forced jump in slave 0 range
    access("jump", 32'h41000000, 4'h0, 1, 32'h0000006F, 0, 32'hCAFEF00D);
    // Ready on the last cycle before timeout still returns data
    access("edge_tmo", 32'h06000040, 4'h0, 0, '0, TMO, 32'hA5A55A5A);
    // Write access to slave 7
    access("wr_s7", 32'h07000004, 4'hF, 0, '0, 0, 32'h0BADC0DE);

    // CPU abandons an access while waiting: no response, back to idle
    cpu_valid = 1'b1;
    cpu_addr  = 32'h02000000;
    cpu_wstrb = '0;
    slv_ready = '0;
    repeat (2) @(negedge clk);
    cpu_valid = 1'b0;
    @(negedge clk);
    check("abandon_cs", 32'(slv_cs), 32'd0);
    check("abandon_ready", 32'(cpu_ready), 32'd0);
    @(negedge clk);
    check("abandon_ready2", 32'(cpu_ready), 32'd0);
    check("abandon_bus_err", 32'(bus_err), 32'(m_err));

    // Error then reset mid-access on slave 4
    access("pre_rst_err", 32'h3F000000, 4'h0, 0, '0, 0, 32'h0);
    cpu_valid = 1'b1;
    cpu_addr  = 32'h04000020;
    slv_ready = '0;
    #1 check("rst_mid_cs0", 32'(slv_cs), 32'h10);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_cs", 32'(slv_cs), 32'd0);
    check("rst_mid_ready", 32'(cpu_ready), 32'd0);
    check("rst_mid_rdata", cpu_rdata, 32'd0);
    check("rst_mid_bus_err", 32'(bus_err), 32'd0);
    model_reset();
    check_capture("rst_mid");
    cpu_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(cpu_ready), 32'd0);
    access("post_rst", 32'h04000020, 4'h0, 0, '0, 1, 32'h600DF00D);

    // Randomized accesses
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int          d;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[29:24] = pfx_tab[$urandom_range(0, NS - 1)];
      d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TMO + 2));
      access("rand", a, 4'($urandom), ($urandom_range(0, 7) == 0), $urandom, d, $urandom);
      if ($urandom_range(0, 9) == 0) pulse_clear();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
